dbus_req_ctrl: RTL
==================

Name: dbus_req_ctrl

Overview:
- Sequences data-memory accesses from the MEM pipeline stage onto the split-handshake data bus.
- Latches the request and generates byte strobes and lane-shifted write data.
- Stalls the pipeline until the response returns, and holds read data until the stage advances.
- Absorbs flushes that arrive mid-transaction without corrupting the bus protocol.

Parameters:
- TIMEOUT, 256, max cycles in REQ+WAIT before bus_err pulses; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- d_valid  in  1  MEM stage has a load/store (MemtoReg|MemWrite)
- mem_write  in  1  1=store, 0=load
- size  in  2  0=byte, 1=half, 2=word; 3 is illegal
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, lane 0 aligned (forwarded value)
- stall_in  in  1  external MEM stall from the hazard unit; 0 = stage advances this cycle
- flush  in  1  kill the current MEM instruction
- req_valid  out  1  bus request valid
- req_addr  out  32  latched addr, low 2 bits preserved
- req_size  out  2  latched size
- req_strobe  out  4  byte enables; 0000 for loads
- req_data  out  32  lane-shifted store data
- addr_ok  in  1  bus accepted the request
- data_ok  in  1  bus response valid
- rdata  in  32  bus read data
- rdata_out  out  32  captured read data, raw word
- rdata_valid  out  1  rdata_out belongs to the current MEM instruction
- stall_out  out  1  stall request to the hazard unit
- addr_err  out  1  misaligned or illegal-size access; no bus request is made
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE; all outputs 0, abort=0, timeout counter=0.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - addr_err = d_valid & misaligned, combinational.
  - Request suppressed, no stall.
- Strobe:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
  - req_data = wdata << (8*addr[1:0]).
  - Computed at issue and registered.
- IDLE:
  - If d_valid & !flush & !addr_err: latch fields, go to REQ next cycle; stall_out=1 this cycle.
  - Otherwise stay; stall_out=0.
- REQ:
  - req_valid=1; latched fields held stable until addr_ok.
  - addr_ok&data_ok in the same cycle → DONE, with rdata captured that cycle.
  - addr_ok alone → WAIT.
  - Else stay.
- WAIT:
  - req_valid=0.
  - data_ok → DONE and capture rdata (loads only; stores leave rdata_out unchanged).
- DONE:
  - stall_out=0, rdata_valid=1 for loads.
  - Stays until stall_in=0, then → IDLE next cycle.
  - The request is never reissued while the stage is held.
- stall_out = 1 in REQ and WAIT, plus the IDLE issue cycle; 0 in DONE.
- Flush:
  - In REQ or WAIT: set abort; the transaction still completes on the bus. On completion go to IDLE, not DONE; rdata_valid stays 0; abort clears.
  - In DONE: → IDLE next cycle; rdata_valid=0 from that cycle.
  - In IDLE: blocks issue that cycle.
- A new d_valid while aborting is ignored until IDLE; stall_out stays 1 while the bus is busy.
- Watchdog:
  - Counter increments each cycle in REQ/WAIT and clears on leaving them.
  - At count==TIMEOUT-1, bus_err pulses once; the state is unchanged.
  - Saturates; no repeat pulse.
- reset mid-transaction → IDLE immediately. Bus-side recovery is the bus's responsibility.
- Latency: minimum load-to-DONE is 2 cycles (issue cycle + REQ cycle with addr_ok&data_ok).

Test Plan:
- Word load at 0x80001000, bus returns addr_ok&data_ok in the first REQ cycle with rdata=0xDEADBEEF → stall_out high for 2 cycles; rdata_out=0xDEADBEEF, rdata_valid=1 in DONE.
- Byte store wdata=0x000000AB to 0x80001003, addr_ok after 3 cycles, data_ok 2 cycles later → req_strobe=1000, req_data=0xAB000000; fields stable throughout REQ; stall_out=1 for 6 cycles.
- Load completes while stall_in=1 for 4 more cycles → exactly one req_valid handshake; DONE held; IDLE after stall_in drops.
- Flush asserted in WAIT, data_ok 3 cycles later → FSM returns to IDLE; rdata_valid never 1; next d_valid is issued only after that.
- Half load at 0x80001001 → addr_err=1, req_valid=0, stall_out=0. Then a word load with TIMEOUT=8 and no addr_ok → single bus_err pulse at the 8th REQ cycle.

Source files
------------

// File: rtl/dbus_req_ctrl_if.sv
// Split-handshake data bus between the MEM-stage request controller and data memory.
interface dbus_req_ctrl_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/dbus_req_ctrl.sv
// MEM-stage data bus request sequencer: issues one latched request per access,
// stalls the pipeline until the response returns and absorbs mid-flight flushes.
module dbus_req_ctrl #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_valid,
    input  logic                   mem_write,
    input  logic [1:0]             size,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic                   stall_in,
    input  logic                   flush,
    dbus_req_ctrl_if.master        bus,
    output logic [31:0]            rdata_out,
    output logic                   rdata_valid,
    output logic                   stall_out,
    output logic                   addr_err,
    output logic                   bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               abort;
    logic               lat_write;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               misaligned_c;
    logic               issue_c;
    logic               busy_c;
    logic               busy_next_c;
    logic               kill_c;
    logic               fire_c;
    logic [3:0]         strobe_c;
    logic [31:0]        data_c;

    // Alignment check on the live MEM-stage request
    always_comb begin
        misaligned_c = 1'b0;
        case (size)
            2'd1:    misaligned_c = addr[0];
            2'd2:    misaligned_c = (addr[1:0] != 2'b00);
            2'd3:    misaligned_c = 1'b1;
            default: misaligned_c = 1'b0;
        endcase
    end

    assign addr_err = d_valid & misaligned_c;
    assign issue_c  = (state == ST_IDLE) & d_valid & ~flush & ~misaligned_c;
    assign busy_c   = (state == ST_REQ) | (state == ST_WAIT);
    assign kill_c   = abort | flush;

    // Byte enables and lane-shifted store data, captured only at issue
    always_comb begin
        strobe_c = 4'b0000;
        data_c   = 32'h0;
        if (mem_write) begin
            case (size)
                2'd0:    strobe_c = 4'b0001 << addr[1:0];
                2'd1:    strobe_c = 4'b0011 << addr[1:0];
                default: strobe_c = 4'b1111;
            endcase
            data_c = wdata << {addr[1:0], 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the unregistered pipeline stall
    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_out = issue_c;
                if (issue_c) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_out = 1'b1;
                if (bus.addr_ok && bus.data_ok) begin
                    state_next = kill_c ? ST_IDLE : ST_DONE;
                end else if (bus.addr_ok) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_out = 1'b1;
                if (bus.data_ok) begin
                    state_next = kill_c ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                stall_out = 1'b0;
                if (flush || !stall_in) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Watchdog counts bus-busy cycles of one transaction and saturates
    always_comb begin
        busy_next_c = (state_next == ST_REQ) || (state_next == ST_WAIT);
        cnt_next    = '0;
        if (busy_c && busy_next_c) begin
            cnt_next = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
        end
        fire_c = (TIMEOUT != 0) && busy_next_c && (cnt_next == CNT_FIRE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.req_valid  <= 1'b0;
            bus.req_addr   <= 32'h0;
            bus.req_size   <= 2'd0;
            bus.req_strobe <= 4'b0000;
            bus.req_data   <= 32'h0;
            lat_write      <= 1'b0;
            abort          <= 1'b0;
            cnt            <= '0;
            bus_err        <= 1'b0;
            rdata_out      <= 32'h0;
            rdata_valid    <= 1'b0;
        end else begin
            bus.req_valid <= (state_next == ST_REQ);
            if (issue_c) begin
                bus.req_addr   <= addr;
                bus.req_size   <= size;
                bus.req_strobe <= strobe_c;
                bus.req_data   <= data_c;
                lat_write      <= mem_write;
            end
            // A flushed transaction still runs to completion on the bus
            abort   <= busy_next_c ? (abort | (busy_c & flush)) : 1'b0;
            cnt     <= cnt_next;
            bus_err <= fire_c;
            if ((state_next == ST_DONE) && (state != ST_DONE) && !lat_write) begin
                rdata_out <= bus.rdata;
            end
            rdata_valid <= (state_next == ST_DONE) && !lat_write;
        end
    end

endmodule
